ram_program_loader: RTL and testbench

//  Programming-side sequencer for the 16-word program RAM. It drives the MAR programming mux
//  (MAR_ADDR_PROG / _MAR_PROG), which consumes these signals at the other end, and the RAM

---
 rtl/ram_program_loader.sv | 176 +++++++++++++++++
 tb/tb_ram_program_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// Program-RAM load sequencer: streams bytes into consecutive RAM words through the MAR programming mux.
// Optional trailing checksum byte verification is enabled by defining CHECKSUM_LOAD_EN.
module ram_program_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  output logic [ADDR_W-1:0] MAR_ADDR_PROG,
  output logic [DATA_W-1:0] RAM_DATA_PROG,
  output logic              _MAR_PROG,
  output logic              _RAM_WE_PROG,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  // state  | meaning
  // IDLE   | bus released, waiting for START
  // WAIT   | DATA_READY high, waiting for a stream byte
  // SETUP  | address/data settle before the strobe
  // WRITE  | _RAM_WE_PROG low for WE_CYCLES clocks
  // HOLD   | strobe released, address/data held; advance or finish
  // FINISH | DONE pulse, bus released on exit
  // CHECK  | (checksum build) accept and compare the checksum byte
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
`ifdef CHECKSUM_LOAD_EN
  localparam logic [2:0] S_CHECK  = 3'd6;
`endif

  localparam int               CNT_W     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [2:0]       state;
  logic [CNT_W-1:0] we_cnt;

`ifdef CHECKSUM_LOAD_EN
  logic [DATA_W-1:0] sum8;
`else
  assign ERROR = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state         <= S_IDLE;
      we_cnt        <= '0;
      DATA_READY    <= 1'b0;
      MAR_ADDR_PROG <= '0;
      RAM_DATA_PROG <= '0;
      _MAR_PROG     <= 1'b1;
      _RAM_WE_PROG  <= 1'b1;
      CPU_HOLD      <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
`ifdef CHECKSUM_LOAD_EN
      sum8          <= '0;
      ERROR         <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state         <= S_WAIT;
            MAR_ADDR_PROG <= '0;
            RAM_DATA_PROG <= '0;
            _MAR_PROG     <= 1'b0;
            CPU_HOLD      <= 1'b1;
            BUSY          <= 1'b1;
            DATA_READY    <= 1'b1;
`ifdef CHECKSUM_LOAD_EN
            sum8          <= '0;
            ERROR         <= 1'b0;
`endif
          end
        end

        S_WAIT: begin
          if (DATA_VALID) begin
            RAM_DATA_PROG <= DATA_IN;
            DATA_READY    <= 1'b0;
            state         <= S_SETUP;
`ifdef CHECKSUM_LOAD_EN
            sum8          <= sum8 + DATA_IN;
`endif
          end
        end

        S_SETUP: begin
          _RAM_WE_PROG <= 1'b0;
          we_cnt       <= WE_LAST;
          state        <= S_WRITE;
        end

        S_WRITE: begin
          if (we_cnt == '0) begin
            _RAM_WE_PROG <= 1'b1;
            state        <= S_HOLD;
          end else begin
            we_cnt <= we_cnt - 1'b1;
          end
        end

        S_HOLD: begin
          // The last address ends the load; the address never wraps.
          if (MAR_ADDR_PROG == ADDR_LAST) begin
`ifdef CHECKSUM_LOAD_EN
            state      <= S_CHECK;
            DATA_READY <= 1'b1;
`else
            state      <= S_FINISH;
            DONE       <= 1'b1;
`endif
          end else begin
            MAR_ADDR_PROG <= MAR_ADDR_PROG + 1'b1;
            DATA_READY    <= 1'b1;
            state         <= S_WAIT;
          end
        end

        S_FINISH: begin
          _MAR_PROG     <= 1'b1;
          CPU_HOLD      <= 1'b0;
          BUSY          <= 1'b0;
          MAR_ADDR_PROG <= '0;
          RAM_DATA_PROG <= '0;
          state         <= S_IDLE;
        end

`ifdef CHECKSUM_LOAD_EN
        S_CHECK: begin
          if (DATA_VALID) begin
            DATA_READY <= 1'b0;
            if (DATA_IN == sum8) begin
              state <= S_FINISH;
              DONE  <= 1'b1;
            end else begin
              // CPU stays held after a bad checksum until the next START or RESET.
              ERROR         <= 1'b1;
              _MAR_PROG     <= 1'b1;
              BUSY          <= 1'b0;
              MAR_ADDR_PROG <= '0;
              RAM_DATA_PROG <= '0;
              state         <= S_IDLE;
            end
          end
        end
`endif

        default: begin
          state         <= S_IDLE;
          DATA_READY    <= 1'b0;
          MAR_ADDR_PROG <= '0;
          RAM_DATA_PROG <= '0;
          _MAR_PROG     <= 1'b1;
          _RAM_WE_PROG  <= 1'b1;
          CPU_HOLD      <= 1'b0;
          BUSY          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader: directed load scenarios with random data and gaps,
// write strobes captured from the RAM-side bus and compared against the bytes sent.
module tb_ram_program_loader;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int WEC = 2;
  localparam int NW  = 1 << AW;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          START;
  logic [DW-1:0] DATA_IN;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic [AW-1:0] MAR_ADDR_PROG;
  logic [DW-1:0] RAM_DATA_PROG;
  logic          mar_prog_n;
  logic          ram_we_n;
  logic          CPU_HOLD;
  logic          BUSY;
  logic          DONE;
  logic          ERROR;

  ram_program_loader #(.ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(WEC)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .MAR_ADDR_PROG(MAR_ADDR_PROG),
    .RAM_DATA_PROG(RAM_DATA_PROG), ._MAR_PROG(mar_prog_n), ._RAM_WE_PROG(ram_we_n),
    .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] mon_addr[$];
  logic [DW-1:0] mon_data[$];
  logic [DW-1:0] sent[$];
  int   done_cnt = 0;
  logic prev_we  = 1'b1;
  int   width    = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM-side observer: records each write strobe and checks its shape.
  always @(negedge CLOCK) begin
    if (RESET) begin
      prev_we = 1'b1;
      width   = 0;
    end else begin
      if (!ram_we_n) begin
        if (prev_we) begin
          mon_addr.push_back(MAR_ADDR_PROG);
          mon_data.push_back(RAM_DATA_PROG);
          p_addr = MAR_ADDR_PROG;
          p_data = RAM_DATA_PROG;
          width  = 0;
        end else begin
          check("we_addr_frozen", 32'(MAR_ADDR_PROG), 32'(p_addr));
          check("we_data_frozen", 32'(RAM_DATA_PROG), 32'(p_data));
        end
        width++;
        check("mar_sel_during_we", 32'(mar_prog_n), 32'd0);
      end else if (!prev_we) begin
        check("we_width", 32'(width), 32'(WEC));
      end
      prev_we = ram_we_n;
      if (DONE) done_cnt++;
      if (BUSY) check("mar_low_while_busy", 32'(mar_prog_n), 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_ready();
    logic ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLOCK);
      ok = DATA_READY;
    end
    if (!ok) check("ready_timeout", 32'(DATA_READY), 32'd1);
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLOCK);
      ok = !BUSY;
    end
    if (!ok) check("idle_timeout", 32'(BUSY), 32'd0);
    tick();
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    logic [AW-1:0] a0;
    int p0;
    if (gap > 0) begin
      DATA_VALID = 1'b0;
      wait_ready();
      a0 = MAR_ADDR_PROG;
      p0 = mon_addr.size();
      repeat (gap) tick();
      check("bp_addr_held", 32'(MAR_ADDR_PROG), 32'(a0));
      check("bp_no_extra_we", 32'(mon_addr.size()), 32'(p0));
      check("bp_ready_held", 32'(DATA_READY), 32'd1);
    end
    DATA_IN    = b;
    DATA_VALID = 1'b1;
    wait_ready();
    @(posedge CLOCK);
    #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic begin_load();
    mon_addr.delete();
    mon_data.delete();
    sent.delete();
    done_cnt = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  function automatic logic [DW-1:0] sum_of_sent();
    logic [DW-1:0] s = '0;
    foreach (sent[i]) s = s + sent[i];
    return s;
  endfunction

  task automatic finish_stream();
`ifdef CHECKSUM_LOAD_EN
    send_byte(sum_of_sent(), 0);
`endif
  endtask

  task automatic verify_load(input string tag);
    check({tag, "_pulses"}, 32'(mon_addr.size()), 32'(NW));
    for (int i = 0; i < mon_addr.size() && i < NW; i++) begin
      check({tag, "_addr"}, 32'(mon_addr[i]), 32'(i));
      check({tag, "_data"}, 32'(mon_data[i]), 32'(sent[i]));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(DATA_READY), 32'd0);
    check({tag, "_addr"}, 32'(MAR_ADDR_PROG), 32'd0);
    check({tag, "_data"}, 32'(RAM_DATA_PROG), 32'd0);
    check({tag, "_mar_n"}, 32'(mar_prog_n), 32'd1);
    check({tag, "_we_n"}, 32'(ram_we_n), 32'd1);
    check({tag, "_hold"}, 32'(CPU_HOLD), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_error"}, 32'(ERROR), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b;
    RESET = 1'b1; START = 1'b0; DATA_VALID = 1'b0; DATA_IN = '0;
    repeat (2) tick();
    check_idle("reset");
    RESET = 1'b0;
    tick();

    // Full load of 0x10..0x1F, VALID held high.
    begin_load();
    check("start_busy", 32'(BUSY), 32'd1);
    check("start_hold", 32'(CPU_HOLD), 32'd1);
    check("start_mar_n", 32'(mar_prog_n), 32'd0);
    check("start_ready", 32'(DATA_READY), 32'd1);
    for (int i = 0; i < NW; i++) begin
      b = DW'(16 + i);
      sent.push_back(b);
      send_byte(b, 0);
    end
    finish_stream();
    wait_idle();
    verify_load("full");
    check_idle("full_end");

    // Random data with random gaps; one guaranteed 5-cycle gap.
    begin_load();
    for (int i = 0; i < NW; i++) begin
      b = DW'($urandom);
      sent.push_back(b);
      send_byte(b, (i == 4) ? 5 : int'($urandom_range(0, 5)));
    end
    finish_stream();
    wait_idle();
    verify_load("rand");
    check_idle("rand_end");

    // START pulse mid-load at address 3 is ignored.
    begin_load();
    for (int i = 0; i < 3; i++) begin
      b = DW'($urandom);
      sent.push_back(b);
      send_byte(b, 0);
    end
    wait_ready();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("busy_start_addr", 32'(MAR_ADDR_PROG), 32'd3);
    check("busy_start_busy", 32'(BUSY), 32'd1);
    for (int i = 3; i < NW; i++) begin
      b = DW'($urandom);
      sent.push_back(b);
      send_byte(b, 0);
    end
    finish_stream();
    wait_idle();
    verify_load("busy_start");

    // Reset during the write strobe at address 7.
    begin_load();
    for (int i = 0; i < 8; i++) send_byte(DW'($urandom), 0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge CLOCK);
        seen = !ram_we_n;
      end
      check("rst_we_seen", 32'(ram_we_n), 32'd0);
    end
    check("rst_we_addr", 32'(MAR_ADDR_PROG), 32'd7);
    #2 RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    check("rst_mid_we_n", 32'(ram_we_n), 32'd1);
    check("rst_mid_mar_n", 32'(mar_prog_n), 32'd1);
    check("rst_mid_hold", 32'(CPU_HOLD), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // RESET and START together: RESET wins.
    RESET = 1'b1; START = 1'b1;
    tick();
    check("rst_start_busy", 32'(BUSY), 32'd0);
    check("rst_start_hold", 32'(CPU_HOLD), 32'd0);
    RESET = 1'b0; START = 1'b0;
    tick();
    check_idle("rst_start_idle");

`ifdef CHECKSUM_LOAD_EN
    begin_load();
    for (int i = 0; i < NW; i++) send_byte(8'h11, 0);
    send_byte(8'h10, 0);
    wait_idle();
    check("cks_good_done", 32'(done_cnt), 32'd1);
    check("cks_good_pulses", 32'(mon_addr.size()), 32'(NW));
    check_idle("cks_good_end");

    begin_load();
    for (int i = 0; i < NW; i++) send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    wait_idle();
    check("cks_bad_error", 32'(ERROR), 32'd1);
    check("cks_bad_hold", 32'(CPU_HOLD), 32'd1);
    check("cks_bad_mar_n", 32'(mar_prog_n), 32'd1);
    check("cks_bad_done", 32'(done_cnt), 32'd0);
    check("cks_bad_pulses", 32'(mon_addr.size()), 32'(NW));
    begin_load();
    check("cks_restart_error", 32'(ERROR), 32'd0);
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    check_idle("cks_reset");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
